block_memory_responder: RTL and testbench

//  Main-memory responder for the direct-mapped write-back cache: serves whole-block
//  (4 x 32-bit) read-fill and write-back requests over a valid/ready handshake with a

---
 rtl/block_memory_responder_pkg.sv | 41 ++++
 rtl/block_memory_responder_if.sv | 23 ++
 rtl/block_mem_array.sv | 32 +++
 rtl/block_memory_responder.sv | 102 ++++++++++
 tb/tb_block_memory_responder.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/block_memory_responder_pkg.sv
// Shared widths, block-index slice, FSM encoding and the power-up image of the
// block memory used by the write-back cache's main-memory responder.
package block_memory_responder_pkg;

  localparam int unsigned ADDR_W    = 10;
  localparam int unsigned WORD_W    = 32;
  localparam int unsigned BLK_WORDS = 4;
  localparam int unsigned BLK_W     = WORD_W * BLK_WORDS;
  localparam int unsigned IDX_LSB   = 4;
  localparam int unsigned IDX_MSB   = 9;
  localparam int unsigned IDX_W     = IDX_MSB - IDX_LSB + 1;
  localparam int unsigned NUM_BLKS  = 1 << IDX_W;
  localparam int unsigned WOFF_W    = $clog2(BLK_WORDS);
  localparam int unsigned CNT_W     = 4;

  typedef logic [IDX_W-1:0] blk_idx_t;
  typedef logic [BLK_W-1:0] blk_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic blk_idx_t blk_index(input logic [ADDR_W-1:0] addr);
    return addr[IDX_MSB:IDX_LSB];
  endfunction

  // Power-up contents: word k of the array holds the value k.
  function automatic blk_t init_block(input blk_idx_t idx);
    blk_t blk;
    blk = '0;
    for (int unsigned w = 0; w < BLK_WORDS; w++) begin
      logic [WOFF_W-1:0] wo;
      wo = WOFF_W'(w);
      blk[w*WORD_W +: WORD_W] = WORD_W'({idx, wo});
    end
    return blk;
  endfunction

endpackage

// File: rtl/block_memory_responder_if.sv
// Request/response handshake bundle between the cache controller and the responder.
interface block_memory_responder_if;
  import block_memory_responder_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [BLK_W-1:0]  req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [BLK_W-1:0]  resp_rdata;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata
  );
endinterface

// File: rtl/block_mem_array.sv
// 64 x 128-bit block store with a single enabled access port and a registered
// read/acknowledge output; reset clears only the output register.
module block_mem_array
  import block_memory_responder_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  input  logic     en,
  input  logic     we,
  input  blk_idx_t idx,
  input  blk_t     wdata,
  output blk_t     rdata
);

  // Cells hold contents XOR the power-up image, so a zero-initialised store
  // reads back as word k = k without any reset or load sequence.
  blk_t mem [NUM_BLKS];

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata <= '0;
    end else if (en) begin
      if (we) begin
        mem[idx] <= wdata ^ init_block(idx);
        rdata    <= wdata;
      end else begin
        rdata    <= mem[idx] ^ init_block(idx);
      end
    end
  end

endmodule

// File: rtl/block_memory_responder.sv
// Main-memory responder: accepts one whole-block read or write-back at a time
// and answers after a fixed LATENCY with all outputs registered.
module block_memory_responder
  import block_memory_responder_pkg::*;
#(
  parameter int unsigned LATENCY = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  block_memory_responder_if.slave  bus
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             req_ready_q, req_ready_d;
  logic             resp_valid_q, resp_valid_d;
  logic             accept;
  logic             commit;
  blk_idx_t         idx_q;
  logic             write_q;
  blk_t             wdata_q;
  blk_t             rdata;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    req_ready_d  = req_ready_q;
    resp_valid_d = resp_valid_q;
    accept       = 1'b0;
    commit       = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_ready_q && bus.req_valid) begin
          accept      = 1'b1;
          cnt_d       = CNT_W'(LATENCY - 1);
          req_ready_d = 1'b0;
          state_d     = BUSY;
        end else begin
          req_ready_d = 1'b1;
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          commit       = 1'b1;
          resp_valid_d = 1'b1;
          state_d      = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        if (bus.resp_ready) begin
          resp_valid_d = 1'b0;
          req_ready_d  = 1'b1;
          state_d      = IDLE;
        end
      end
      default: begin
        state_d      = IDLE;
        req_ready_d  = 1'b0;
        resp_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      idx_q        <= '0;
      write_q      <= 1'b0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      if (accept) begin
        idx_q   <= blk_index(bus.req_addr);
        write_q <= bus.req_write;
        wdata_q <= bus.req_wdata;
      end
    end
  end

  block_mem_array u_array (
    .clk   (clk),
    .reset (reset),
    .en    (commit),
    .we    (write_q),
    .idx   (idx_q),
    .wdata (wdata_q),
    .rdata (rdata)
  );

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = rdata;

endmodule

// File: tb/tb_block_memory_responder.sv
// Directed bench for block_memory_responder: reset, reads, write-back, response
// hold, reset during a write, and back-to-back requests.
module tb_block_memory_responder;
  import block_memory_responder_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  block_memory_responder_if bus ();

  block_memory_responder #(.LATENCY(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [BLK_W-1:0] exp_block(input logic [ADDR_W-1:0] addr);
    logic [BLK_W-1:0] b;
    int unsigned base;
    base = int'(addr[9:4]) * 4;
    b = '0;
    for (int w = 0; w < 4; w++) b[w*32 +: 32] = 32'(base + w);
    return b;
  endfunction

  // Issues one request, waits for the response, consumes it. lat = edges from
  // acceptance to the sample where resp_valid is seen, or -1 on timeout.
  task automatic do_req(input logic wr, input logic [ADDR_W-1:0] addr,
                        input logic [BLK_W-1:0] wdata,
                        output int lat, output logic [BLK_W-1:0] data);
    int guard;
    lat = -1;
    data = '0;
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    guard = 0;
    while (!bus.req_ready && guard < 20) begin
      step();
      guard++;
    end
    if (!bus.req_ready) begin
      bus.req_valid = 1'b0;
      return;
    end
    step();
    bus.req_valid = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (bus.resp_valid) begin
        lat = i;
        break;
      end
    end
    if (lat < 0) return;
    data = bus.resp_rdata;
    bus.resp_ready = 1'b1;
    step();
    bus.resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      total_cnt++;
      if (bus.req_ready !== 1'b0) $display("FAIL reset_req_ready cyc%0d got %b want 0", i, bus.req_ready);
      else pass_cnt++;
      total_cnt++;
      if (bus.resp_valid !== 1'b0) $display("FAIL reset_resp_valid cyc%0d got %b want 0", i, bus.resp_valid);
      else pass_cnt++;
      total_cnt++;
      if (bus.resp_rdata !== '0) $display("FAIL reset_rdata cyc%0d got %h want 0", i, bus.resp_rdata);
      else pass_cnt++;
    end
    reset = 1'b0;
    step();
    total_cnt++;
    if (bus.req_ready !== 1'b1) $display("FAIL ready_after_reset got %b want 1", bus.req_ready);
    else pass_cnt++;
  endtask

  task automatic test_read();
    int lat;
    logic [BLK_W-1:0] d;
    do_req(1'b0, 10'h010, '0, lat, d);
    total_cnt++;
    if (lat !== 4) $display("FAIL read_latency got %0d want 4", lat);
    else pass_cnt++;
    total_cnt++;
    if (d !== {32'h7, 32'h6, 32'h5, 32'h4}) $display("FAIL read_010 got %h want %h", d, {32'h7, 32'h6, 32'h5, 32'h4});
    else pass_cnt++;
  endtask

  task automatic test_write_read();
    int lat;
    logic [BLK_W-1:0] d;
    logic [BLK_W-1:0] wblk;
    wblk = {32'hD, 32'hC, 32'hB, 32'hA};
    do_req(1'b1, 10'h3F0, wblk, lat, d);
    total_cnt++;
    if (lat !== 4) $display("FAIL write_latency got %0d want 4", lat);
    else pass_cnt++;
    total_cnt++;
    if (d !== wblk) $display("FAIL write_ack got %h want %h", d, wblk);
    else pass_cnt++;
    do_req(1'b0, 10'h3FC, '0, lat, d);
    total_cnt++;
    if (lat !== 4) $display("FAIL readback_latency got %0d want 4", lat);
    else pass_cnt++;
    total_cnt++;
    if (d !== wblk) $display("FAIL readback_3FC got %h want %h", d, wblk);
    else pass_cnt++;
  endtask

  task automatic test_resp_hold();
    logic [BLK_W-1:0] want;
    int guard;
    want = {32'hB, 32'hA, 32'h9, 32'h8};
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = 10'h020;
    step();
    bus.req_valid = 1'b0;
    guard = 0;
    while (!bus.resp_valid && guard < 20) begin
      step();
      guard++;
    end
    total_cnt++;
    if (bus.resp_valid !== 1'b1) $display("FAIL hold_resp_arrive got %b want 1", bus.resp_valid);
    else pass_cnt++;
    bus.req_valid = 1'b1;
    bus.req_addr  = 10'h030;
    for (int i = 0; i < 3; i++) begin
      step();
      total_cnt++;
      if (bus.resp_valid !== 1'b1) $display("FAIL hold_valid cyc%0d got %b want 1", i, bus.resp_valid);
      else pass_cnt++;
      total_cnt++;
      if (bus.resp_rdata !== want) $display("FAIL hold_rdata cyc%0d got %h want %h", i, bus.resp_rdata, want);
      else pass_cnt++;
      total_cnt++;
      if (bus.req_ready !== 1'b0) $display("FAIL hold_req_ready cyc%0d got %b want 0", i, bus.req_ready);
      else pass_cnt++;
    end
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b1;
    step();
    bus.resp_ready = 1'b0;
    total_cnt++;
    if (bus.resp_valid !== 1'b0) $display("FAIL hold_release_valid got %b want 0", bus.resp_valid);
    else pass_cnt++;
    total_cnt++;
    if (bus.req_ready !== 1'b1) $display("FAIL hold_release_ready got %b want 1", bus.req_ready);
    else pass_cnt++;
    for (int i = 0; i < 6; i++) begin
      step();
      total_cnt++;
      if (bus.resp_valid !== 1'b0) $display("FAIL hold_no_accept cyc%0d got %b want 0", i, bus.resp_valid);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid_write();
    int lat;
    logic [BLK_W-1:0] d;
    // reset two edges into BUSY
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = 10'h040;
    bus.req_wdata = {4{32'hDEADBEEF}};
    step();
    bus.req_valid = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
    total_cnt++;
    if (bus.req_ready !== 1'b0 || bus.resp_valid !== 1'b0)
      $display("FAIL midrst_outputs got ready=%b valid=%b want 0/0", bus.req_ready, bus.resp_valid);
    else pass_cnt++;
    reset = 1'b0;
    step();
    total_cnt++;
    if (bus.req_ready !== 1'b1) $display("FAIL midrst_ready got %b want 1", bus.req_ready);
    else pass_cnt++;
    do_req(1'b0, 10'h040, '0, lat, d);
    total_cnt++;
    if (d !== {32'h13, 32'h12, 32'h11, 32'h10}) $display("FAIL midrst_read_040 got %h want %h", d, {32'h13, 32'h12, 32'h11, 32'h10});
    else pass_cnt++;
    // reset exactly on the commit edge
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = 10'h050;
    bus.req_wdata = {4{32'hCAFEF00D}};
    step();
    bus.req_valid = 1'b0;
    step();
    step();
    step();
    reset = 1'b1;
    step();
    total_cnt++;
    if (bus.resp_valid !== 1'b0) $display("FAIL commitrst_valid got %b want 0", bus.resp_valid);
    else pass_cnt++;
    reset = 1'b0;
    step();
    do_req(1'b0, 10'h050, '0, lat, d);
    total_cnt++;
    if (d !== {32'h17, 32'h16, 32'h15, 32'h14}) $display("FAIL commitrst_read_050 got %h want %h", d, {32'h17, 32'h16, 32'h15, 32'h14});
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [ADDR_W-1:0] addrs [6];
    int acc_cyc [6];
    int n_acc, n_resp;
    logic accepting;
    for (int i = 0; i < 6; i++) addrs[i] = (i % 2 == 0) ? 10'h100 : 10'h2A8;
    n_acc = 0;
    n_resp = 0;
    bus.req_valid  = 1'b1;
    bus.req_write  = 1'b0;
    bus.req_addr   = addrs[0];
    bus.resp_ready = 1'b1;
    for (int cyc = 0; cyc < 100 && n_resp < 6; cyc++) begin
      accepting = bus.req_ready && bus.req_valid;
      step();
      if (accepting) begin
        acc_cyc[n_acc] = cyc;
        n_acc++;
        if (n_acc < 6) bus.req_addr = addrs[n_acc];
        else bus.req_valid = 1'b0;
      end
      if (bus.resp_valid) begin
        total_cnt++;
        if (bus.resp_rdata !== exp_block(addrs[n_resp]))
          $display("FAIL b2b_data #%0d got %h want %h", n_resp, bus.resp_rdata, exp_block(addrs[n_resp]));
        else pass_cnt++;
        total_cnt++;
        if (n_resp >= n_acc || cyc - acc_cyc[n_resp] != 4)
          $display("FAIL b2b_latency #%0d got %0d want 4", n_resp, cyc - acc_cyc[n_resp]);
        else pass_cnt++;
        if (n_resp > 0) begin
          total_cnt++;
          if (acc_cyc[n_resp] - acc_cyc[n_resp-1] != 6)
            $display("FAIL b2b_spacing #%0d got %0d want 6", n_resp, acc_cyc[n_resp] - acc_cyc[n_resp-1]);
          else pass_cnt++;
        end
        n_resp++;
      end
    end
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b0;
    total_cnt++;
    if (n_resp !== 6 || n_acc !== 6) $display("FAIL b2b_count got acc=%0d resp=%0d want 6/6", n_acc, n_resp);
    else pass_cnt++;
  endtask

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.resp_ready = 1'b0;
    reset = 1'b1;
    test_reset();
    test_read();
    test_write_read();
    test_resp_hold();
    test_reset_mid_write();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
